// File: rtl/addr_tree_seq.sv
// -----------------------------------------------------------------------------
// addr_tree_seq
//   Sequencer and accumulator for one adder-tree instance. Accepts a job of
//   num_vec vectors over a valid/ready stream, drives the tree stage enables
//   with the right pipeline alignment, sign-extends and accumulates each
//   registered tree result, and returns the sum over a valid/ready handshake.
//
// Ports:
//   CLK, RESET          clock and synchronous active-high reset
//   start, num_vec      job request (honoured only in IDLE) and vector count
//   in_valid, in_ready  upstream vector stream handshake
//   addr_en_m1, addr_en tree pre-final / final stage enables
//   tree_out            registered tree output (signed, PREC_OUT bits)
//   acc_out, ovf        accumulated sum and sticky wrap flag
//   res_valid, res_ready result handshake
//   busy                high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module addr_tree_seq #(
    parameter int PREC_OUT = 10,
    parameter int ACC_W    = 16,
    parameter int CNT_W    = 8,
    parameter int PIPE     = 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_vec,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                addr_en_m1,
    output logic                addr_en,
    input  logic [PREC_OUT-1:0] tree_out,
    output logic [ACC_W-1:0]    acc_out,
    output logic                ovf,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] num_reg;
    logic [CNT_W-1:0] issue_cnt_reg;
    logic [CNT_W-1:0] cap_cnt_reg;
    logic [ACC_W-1:0] acc_reg;
    logic             ovf_reg;

    logic             acc_beat;
    logic             cap;
    logic             cap_ok;
    logic [CNT_W:0]   issue_inc;
    logic [CNT_W:0]   cap_inc;
    logic             issue_last;
    logic             cap_last;
    logic [ACC_W-1:0] tree_ext;
    logic [ACC_W-1:0] sum;
    logic             add_ovf;

    assign in_ready = (state_reg == RUN);
    assign acc_beat = in_valid && in_ready;

    // Enable delay line. The capture strobe lines up with the cycle in
    // which the tree's registered output holds the result of a beat.
    generate
        if (PIPE != 0) begin : g_pipe
            logic en_d1_reg;
            logic cap_d_reg;
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    en_d1_reg <= 1'b0;
                    cap_d_reg <= 1'b0;
                end else begin
                    en_d1_reg <= acc_beat;
                    cap_d_reg <= en_d1_reg;
                end
            end
            assign addr_en_m1 = acc_beat;
            assign addr_en    = en_d1_reg;
            assign cap        = cap_d_reg;
        end else begin : g_flat
            logic cap_d_reg;
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    cap_d_reg <= 1'b0;
                end else begin
                    cap_d_reg <= acc_beat;
                end
            end
            assign addr_en_m1 = 1'b0;
            assign addr_en    = acc_beat;
            assign cap        = cap_d_reg;
        end
    endgenerate

    assign cap_ok = cap && ((state_reg == RUN) || (state_reg == DRAIN));

    // Counters are compared one bit wider so a full-scale job count
    // (all ones) never aliases through a wrap.
    assign issue_inc  = {1'b0, issue_cnt_reg} + {{CNT_W{1'b0}}, 1'b1};
    assign cap_inc    = {1'b0, cap_cnt_reg} + {{CNT_W{1'b0}}, 1'b1};
    assign issue_last = (issue_inc == {1'b0, num_reg});
    assign cap_last   = (cap_inc == {1'b0, num_reg});

    // Sign extension of the tree result to the accumulator width.
    generate
        for (genvar gi = 0; gi < ACC_W; gi++) begin : g_ext
            if (gi < PREC_OUT) begin : g_bit
                assign tree_ext[gi] = tree_out[gi];
            end else begin : g_sign
                assign tree_ext[gi] = tree_out[PREC_OUT-1];
            end
        end
    endgenerate

    assign sum = acc_reg + tree_ext;
    // Signed overflow: both operands share a sign that the result lacks.
    assign add_ovf = (acc_reg[ACC_W-1] == tree_ext[ACC_W-1]) &&
                     (sum[ACC_W-1] != acc_reg[ACC_W-1]);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start && (num_vec != '0)) state_next = RUN;
            RUN: begin
                if (cap_ok && cap_last)            state_next = DONE;
                else if (acc_beat && issue_last)   state_next = DRAIN;
            end
            DRAIN:   if (cap_ok && cap_last)       state_next = DONE;
            DONE:    if (res_ready)                state_next = IDLE;
            default:                               state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= IDLE;
            num_reg       <= '0;
            issue_cnt_reg <= '0;
            cap_cnt_reg   <= '0;
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == IDLE) && start && (num_vec != '0)) begin
                num_reg       <= num_vec;
                issue_cnt_reg <= '0;
                cap_cnt_reg   <= '0;
                acc_reg       <= '0;
                ovf_reg       <= 1'b0;
            end
            if (acc_beat) begin
                issue_cnt_reg <= issue_inc[CNT_W-1:0];
            end
            if (cap_ok) begin
                acc_reg     <= sum;
                ovf_reg     <= ovf_reg | add_ovf;
                cap_cnt_reg <= cap_inc[CNT_W-1:0];
            end
        end
    end

    assign acc_out   = acc_reg;
    assign ovf       = ovf_reg;
    assign res_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_addr_tree_seq.sv
// -----------------------------------------------------------------------------
// tb_addr_tree_seq
//   Three sequencer instances: [0] PIPE=1/ACC_W=16, [1] PIPE=0/ACC_W=16,
//   [2] PIPE=1/ACC_W=10. A behavioural tree model registers the bus data
//   using the DUT enables; expected job results are queued when a job is
//   driven and compared when the result handshake completes.
// -----------------------------------------------------------------------------
module tb_addr_tree_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_s     [3];
    logic [7:0] num_s       [3];
    logic       in_valid_s  [3];
    logic       in_ready_s  [3];
    logic       m1_s        [3];
    logic       en_s        [3];
    logic [9:0] vec_s       [3];
    logic [9:0] st1_s       [3];
    logic [9:0] tout_s      [3];
    logic       ovf_s       [3];
    logic       res_valid_s [3];
    logic       res_ready_s [3];
    logic       busy_s      [3];
    logic [15:0] acc0, acc1;
    logic [9:0]  acc10;

    int vals [256];
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int d;
        int acc;
        int ovf;
    } exp_t;
    exp_t exp_q [$];
    exp_t mon_e;

    addr_tree_seq #(.PREC_OUT(10), .ACC_W(16), .CNT_W(8), .PIPE(1)) u_p1 (
        .CLK(clk), .RESET(rst), .start(start_s[0]), .num_vec(num_s[0]),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .addr_en_m1(m1_s[0]), .addr_en(en_s[0]), .tree_out(tout_s[0]),
        .acc_out(acc0), .ovf(ovf_s[0]), .res_valid(res_valid_s[0]),
        .res_ready(res_ready_s[0]), .busy(busy_s[0])
    );

    addr_tree_seq #(.PREC_OUT(10), .ACC_W(16), .CNT_W(8), .PIPE(0)) u_p0 (
        .CLK(clk), .RESET(rst), .start(start_s[1]), .num_vec(num_s[1]),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .addr_en_m1(m1_s[1]), .addr_en(en_s[1]), .tree_out(tout_s[1]),
        .acc_out(acc1), .ovf(ovf_s[1]), .res_valid(res_valid_s[1]),
        .res_ready(res_ready_s[1]), .busy(busy_s[1])
    );

    addr_tree_seq #(.PREC_OUT(10), .ACC_W(10), .CNT_W(8), .PIPE(1)) u_w10 (
        .CLK(clk), .RESET(rst), .start(start_s[2]), .num_vec(num_s[2]),
        .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
        .addr_en_m1(m1_s[2]), .addr_en(en_s[2]), .tree_out(tout_s[2]),
        .acc_out(acc10), .ovf(ovf_s[2]), .res_valid(res_valid_s[2]),
        .res_ready(res_ready_s[2]), .busy(busy_s[2])
    );

    // Tree model: pre-final register on addr_en_m1, output register on
    // addr_en. Instance 1 is a single-stage tree fed straight from the bus.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (m1_s[k]) st1_s[k] <= vec_s[k];
            if (en_s[k]) tout_s[k] <= (k == 1) ? vec_s[k] : st1_s[k];
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int acc_of(input int d);
        case (d)
            0:       return $signed(acc0);
            1:       return $signed(acc1);
            default: return $signed(acc10);
        endcase
    endfunction

    // Result monitor: one line per completed job.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst && res_valid_s[k] && res_ready_s[k]) begin
                if (exp_q.size() == 0) begin
                    check_val("result_unexpected", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("result_dut", k, mon_e.d);
                    check_val("result_acc", acc_of(k), mon_e.acc);
                    check_val("result_ovf", int'(ovf_s[k]), mon_e.ovf);
                    $display("result dut=%0d acc=%0d ovf=%0d exp_acc=%0d exp_ovf=%0d",
                             k, acc_of(k), ovf_s[k], mon_e.acc, mon_e.ovf);
                end
            end
        end
    end

    task automatic check_idle(input string tag, input int d);
        check_val({tag, "_acc"},       acc_of(d), 0);
        check_val({tag, "_ovf"},       int'(ovf_s[d]), 0);
        check_val({tag, "_res_valid"}, int'(res_valid_s[d]), 0);
        check_val({tag, "_in_ready"},  int'(in_ready_s[d]), 0);
        check_val({tag, "_en_m1"},     int'(m1_s[d]), 0);
        check_val({tag, "_en"},        int'(en_s[d]), 0);
        check_val({tag, "_busy"},      int'(busy_s[d]), 0);
    endtask

    // Runs one job on instance d using vals[0..n-1].
    //   toggle: in_valid alternates 1,0,1,...; otherwise held high.
    //   hold:   cycles res_ready stays low in DONE (start pulsed meanwhile);
    //           0 means res_ready is already high when res_valid rises.
    task automatic run_job(input int d, input int n, input bit toggle, input int hold);
        int w, s, u, eo, i, cyc, last_beat, rv_cyc;
        int rdy_cnt, en_cnt, m1_cnt, acc_hold;
        bit pipe;
        pipe = (d != 1);
        w    = (d == 2) ? 10 : 16;
        s = 0; eo = 0;
        for (int k = 0; k < n; k++) begin
            s = s + vals[k];
            if (s > (1 << (w - 1)) - 1 || s < -(1 << (w - 1))) eo = 1;
            u = s & ((1 << w) - 1);
            if (u >= (1 << (w - 1))) u = u - (1 << w);
            s = u;
        end
        exp_q.push_back('{d, s, eo});

        @(posedge clk); #1;
        res_ready_s[d] = (hold == 0);
        start_s[d] = 1'b1;
        num_s[d]   = n[7:0];
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        num_s[d]   = 8'd1;          // latched copy must be used from here on

        i = 0; cyc = 0; last_beat = 0;
        rdy_cnt = 0; en_cnt = 0; m1_cnt = 0;
        while (i < n && cyc < 2000) begin
            in_valid_s[d] = toggle ? (cyc % 2 == 0) : 1'b1;
            vec_s[d]      = vals[i][9:0];
            @(negedge clk);
            if (cyc == 0) check_val("busy_in_run", int'(busy_s[d]), 1);
            if (in_ready_s[d]) rdy_cnt++;
            if (en_s[d])       en_cnt++;
            if (m1_s[d])       m1_cnt++;
            if (in_valid_s[d] && in_ready_s[d]) begin
                i++;
                last_beat = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid_s[d] = 1'b0;
        if (i < n) check_val("beat_timeout", i, n);

        rv_cyc = -1;
        while (rv_cyc < 0 && cyc < last_beat + 20) begin
            @(negedge clk);
            if (in_ready_s[d]) rdy_cnt++;
            if (en_s[d])       en_cnt++;
            if (m1_s[d])       m1_cnt++;
            if (res_valid_s[d]) begin
                rv_cyc = cyc;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (rv_cyc < 0) check_val("res_valid_timeout", 0, 1);
        else            check_val("res_latency", rv_cyc - last_beat, pipe ? 3 : 2);
        check_val("addr_en_pulses", en_cnt, n);
        check_val("addr_en_m1_pulses", m1_cnt, pipe ? n : 0);
        if (!toggle) check_val("in_ready_cycles", rdy_cnt, n);

        acc_hold = acc_of(d);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            start_s[d] = (h == 1);
            num_s[d]   = 8'd3;
            @(negedge clk);
            check_val("hold_res_valid", int'(res_valid_s[d]), 1);
            check_val("hold_acc", acc_of(d), acc_hold);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            start_s[d]     = 1'b0;
            res_ready_s[d] = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        res_ready_s[d] = 1'b0;
        @(negedge clk);
        check_val("after_res_valid", int'(res_valid_s[d]), 0);
        check_val("after_busy", int'(busy_s[d]), 0);
        check_val("after_acc_kept", acc_of(d), acc_hold);
        $display("job dut=%0d n=%0d toggle=%0d hold=%0d done", d, n, toggle, hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0; num_s[k] = 8'd0; in_valid_s[k] = 1'b0;
            vec_s[k] = 10'd0; res_ready_s[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_idle("reset", k);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single beat, pipelined tree
        vals[0] = 37;
        run_job(0, 1, 1'b0, 0);

        // Back-to-back beats, full-range tree values
        vals[0] = 100; vals[1] = -50; vals[2] = 511; vals[3] = -512;
        run_job(0, 4, 1'b0, 0);

        // Single-stage tree with gapped input
        vals[0] = 10; vals[1] = -20; vals[2] = 30;
        run_job(1, 3, 1'b1, 0);

        // Narrow accumulator wraps, then ovf clears on the next job
        vals[0] = 500; vals[1] = 100;
        run_job(2, 2, 1'b0, 0);
        vals[0] = 5;
        run_job(2, 1, 1'b0, 0);

        // Consumer stalls in DONE while start is pulsed
        vals[0] = 3; vals[1] = 4;
        run_job(0, 2, 1'b0, 5);

        // Zero-length job is ignored; stray in_valid produces no enables
        @(posedge clk); #1;
        start_s[0] = 1'b1; num_s[0] = 8'd0; in_valid_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        @(negedge clk);
        check_val("zero_job_busy", int'(busy_s[0]), 0);
        check_val("zero_job_in_ready", int'(in_ready_s[0]), 0);
        check_val("idle_valid_en", int'(en_s[0]), 0);
        check_val("idle_valid_en_m1", int'(m1_s[0]), 0);
        @(posedge clk); #1;
        in_valid_s[0] = 1'b0;

        // Reset in DRAIN with one capture still pending
        start_s[0] = 1'b1; num_s[0] = 8'd2;
        @(posedge clk); #1;
        start_s[0] = 1'b0; in_valid_s[0] = 1'b1; vec_s[0] = 10'd7;
        @(posedge clk); #1;
        vec_s[0] = 10'd9;
        @(posedge clk); #1;
        in_valid_s[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("drain_reset", 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("post_reset_acc", acc_of(0), 0);
        check_val("post_reset_res_valid", int'(res_valid_s[0]), 0);

        vals[0] = -8; vals[1] = 21; vals[2] = 100;
        run_job(0, 3, 1'b0, 0);

        // Full-scale job count with random values
        for (int k = 0; k < 255; k++) vals[k] = int'($urandom_range(1023)) - 512;
        run_job(0, 255, 1'b0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/addr_tree_seq.md
Name: addr_tree_seq

Overview:
Sequencer and accumulator for one adder-tree instance. It accepts a job of NUM_VEC input vectors over a valid/ready stream and drives the tree's stage enables (addr_en_m1, addr_en) with the correct pipeline alignment. It sign-extends and accumulates each registered tree result into a wide sum, then returns that sum through a valid/ready result handshake. It sits between the tile controller and the adder tree; input vector data goes straight to the tree, and this block only gates when the tree samples it.

Parameters:
PREC_OUT, 10, width of the tree's registered output (input precision plus log2 of input count); treated as signed.
ACC_W, 16, accumulator and result width; must be at least PREC_OUT.
CNT_W, 8, width of the vector-count field.
PIPE, 1, 1 = tree built with its internal pipeline stage (uses addr_en_m1); 0 = single-stage tree.

Ports:
CLK  in  1  clock; the block's only clock.
RESET  in  1  synchronous, active-high reset.
start  in  1  job start request; honoured only in IDLE.
num_vec  in  CNT_W  vectors in the job; sampled when start is honoured.
in_valid  in  1  upstream vector present on the tree input bus.
in_ready  out  1  block accepts a vector this cycle.
addr_en_m1  out  1  tree pre-final stage enable; constant 0 when PIPE=0.
addr_en  out  1  tree final-stage enable.
tree_out  in  PREC_OUT  registered tree output, signed.
acc_out  out  ACC_W  accumulated signed sum.
ovf  out  1  sticky: accumulator wrapped during the current job.
res_valid  out  1  acc_out holds the final job result.
res_ready  in  1  consumer accepts the result.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high.
- Reset: state goes to IDLE. acc_out=0, ovf=0, res_valid=0, in_ready=0, addr_en_m1=0, addr_en=0, busy=0. The delay line and all counters clear. Beats in flight are discarded. Reset wins over every other input in the same cycle.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 with num_vec!=0: latch num_vec, clear acc_out, ovf and the issue/capture counters, go to RUN.
  - start=1 with num_vec=0: ignored; stay in IDLE.
- Beat acceptance: in_ready=1 only in RUN. A beat is accepted when in_valid && in_ready (call this acc_beat).
- RUN:
  - On each accepted beat, issue_cnt increments.
  - When the accepted beat makes issue_cnt equal num_vec, go to DRAIN; in_ready drops the following cycle.
- Enable timing, PIPE=1:
  - addr_en_m1 = acc_beat, combinational, in the same cycle the data is on the bus.
  - addr_en = acc_beat delayed 1 cycle.
  - Capture strobe cap = addr_en delayed 1 cycle.
- Enable timing, PIPE=0:
  - addr_en = acc_beat, combinational.
  - cap = acc_beat delayed 1 cycle.
- Latency from an accepted beat in cycle t:
  - cap asserts in cycle t+2 when PIPE=1, t+1 when PIPE=0.
  - res_valid rises one cycle after the final cap.
- Accumulate on cap: acc_out <= acc_out + sign_extend(tree_out) to ACC_W. Arithmetic is two's-complement modulo 2^ACC_W. If a signed overflow occurs, set ovf and keep it set until the next honoured start. cap_cnt increments on each cap.
- RUN or DRAIN to DONE: on the cap where cap_cnt+1 equals num_vec. The final addition happens on that same edge. Back-to-back beats (one per cycle) must be sustained with no bubbles.
- DONE:
  - res_valid=1; acc_out and ovf are held stable.
  - res_valid && res_ready: go to IDLE, res_valid drops next cycle. acc_out keeps its value until the next honoured start.
  - res_ready arriving in the same cycle res_valid rises completes the handshake in that cycle.
- start outside IDLE: ignored, with no effect on the current job.
- in_valid outside RUN: ignored; no enables are generated.
- num_vec changing mid-job: no effect, because the latched copy is used.
- num_vec = 2^CNT_W - 1: must complete with no counter wrap.

Test Plan:
1. PIPE=1, num_vec=1, tree_out=37 in the cap cycle. Beat accepted at cycle t -> addr_en_m1 at t, addr_en at t+1, res_valid at t+3, acc_out=37.
2. PIPE=1, num_vec=4, in_valid held high, tree_out sequence 100, -50, 511, -512 -> exactly 4 cycles of in_ready, no bubbles, acc_out=49, ovf=0.
3. PIPE=0, num_vec=3, in_valid toggling 1,0,1,0,1 -> addr_en_m1 always 0, addr_en exactly 3 pulses, res_valid 1 cycle after the last cap.
4. ACC_W=10, num_vec=2, tree_out 500 then 100 -> acc_out = -424 (600 wraps modulo 2^10), ovf=1. A second job with tree_out=5 -> ovf=0, acc_out=5.
5. res_ready held low 5 cycles in DONE, start pulsed meanwhile -> res_valid stays high, acc_out stable, start ignored. Raising res_ready returns to IDLE; then start with num_vec=0 -> stays IDLE.
6. RESET asserted in DRAIN with 1 cap pending -> next cycle all outputs 0, state IDLE. Pending result is not accumulated after release, and a new job gives the correct sum.
